// File: rtl/exmem_pkg.sv
// Shared pipeline constants for the EX/MEM boundary.
package exmem_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        DW2  = 1'b1
    } exmem_state_t;

endpackage

// File: rtl/exmem_if.sv
// EX -> MEM/WB bundle with the stall back-channel.
interface exmem_if;

    logic        iValid;
    logic        iFlush;
    logic        iMemWait;
    logic        iRWrite;
    logic        iDW;
    logic        iFloat;
    logic        iMWrite;
    logic [1:0]  iWBsrc;
    logic [31:0] iALURes;
    logic [31:0] iStoreLo;
    logic [31:0] iStoreHi;
    logic [4:0]  iDstReg;

    logic        oRWrite;
    logic        oFloat;
    logic        oMWrite;
    logic [1:0]  oWBsrc;
    logic [31:0] oAddr;
    logic [31:0] oData;
    logic [4:0]  oDstReg;
    logic        oBeat;
    logic        oStallUp;

    modport master (
        output iValid, iFlush, iMemWait, iRWrite, iDW, iFloat, iMWrite,
        output iWBsrc, iALURes, iStoreLo, iStoreHi, iDstReg,
        input  oRWrite, oFloat, oMWrite, oWBsrc, oAddr, oData, oDstReg,
        input  oBeat, oStallUp
    );

    modport slave (
        input  iValid, iFlush, iMemWait, iRWrite, iDW, iFloat, iMWrite,
        input  iWBsrc, iALURes, iStoreLo, iStoreHi, iDstReg,
        output oRWrite, oFloat, oMWrite, oWBsrc, oAddr, oData, oDstReg,
        output oBeat, oStallUp
    );

endinterface

// File: rtl/exmem.sv
// EX/MEM pipeline register; splits double-word memory ops into two beats.
module exmem
    import exmem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    exmem_if.slave b
);

    exmem_state_t state;
    logic [31:0]  hi_word;
    logic         live;
    logic         dbl;

    assign live = b.iValid & ~b.iFlush;
    assign dbl  = live & b.iDW & (b.iMWrite | (b.iWBsrc == WB_MEM));

    assign b.oStallUp = (state == DW2) | b.iMemWait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi_word   <= '0;
            b.oRWrite <= 1'b0;
            b.oFloat  <= 1'b0;
            b.oMWrite <= 1'b0;
            b.oWBsrc  <= '0;
            b.oAddr   <= '0;
            b.oData   <= '0;
            b.oDstReg <= '0;
            b.oBeat   <= 1'b0;
        end else if (!b.iMemWait) begin
            unique case (state)
                DW2: begin
                    // second beat reuses the first beat's controls
                    b.oAddr   <= b.oAddr + 32'd4;
                    b.oData   <= hi_word;
                    b.oDstReg <= b.oDstReg | 5'b00001;
                    b.oBeat   <= 1'b1;
                    state     <= IDLE;
                end
                IDLE: begin
                    b.oRWrite <= live & b.iRWrite;
                    b.oMWrite <= live & b.iMWrite;
                    b.oFloat  <= b.iFloat;
                    b.oWBsrc  <= b.iWBsrc;
                    b.oAddr   <= b.iALURes;
                    b.oData   <= b.iStoreLo;
                    b.oDstReg <= b.iDstReg;
                    b.oBeat   <= 1'b0;
                    if (dbl) begin
                        hi_word <= b.iStoreHi;
                        state   <= DW2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exmem.sv
// Scoreboard bench for exmem: directed vectors plus randomized traffic.
module tb_exmem;
    import exmem_pkg::*;

    typedef struct packed {
        logic        rw;
        logic        fl;
        logic        mw;
        logic [1:0]  wb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  dst;
        logic        beat;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    exmem_if bus ();

    exmem dut (
        .clk (clk),
        .rst (rst),
        .b   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic clr();
        bus.iValid   = 1'b0;
        bus.iFlush   = 1'b0;
        bus.iMemWait = 1'b0;
        bus.iRWrite  = 1'b0;
        bus.iDW      = 1'b0;
        bus.iFloat   = 1'b0;
        bus.iMWrite  = 1'b0;
        bus.iWBsrc   = WB_ALU;
        bus.iALURes  = '0;
        bus.iStoreLo = '0;
        bus.iStoreHi = '0;
        bus.iDstReg  = '0;
    endtask

    function automatic exp_t mk(logic rw, logic mw, logic [1:0] wb,
                                logic [31:0] a, logic [31:0] d,
                                logic [4:0] r, logic bt, logic st);
        exp_t e;
        e = '{rw: rw, fl: 1'b0, mw: mw, wb: wb, addr: a, data: d,
              dst: r, beat: bt, stall: st};
        return e;
    endfunction

    task automatic cyc(input exp_t e, input string tag);
        exp_t w;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, ".empty"}, 32'd1, 32'd0);
        end else begin
            w = sb.pop_front();
            chk({tag, ".rw"},    {31'd0, bus.oRWrite}, {31'd0, w.rw});
            chk({tag, ".fl"},    {31'd0, bus.oFloat},  {31'd0, w.fl});
            chk({tag, ".mw"},    {31'd0, bus.oMWrite}, {31'd0, w.mw});
            chk({tag, ".wb"},    {30'd0, bus.oWBsrc},  {30'd0, w.wb});
            chk({tag, ".addr"},  bus.oAddr, w.addr);
            chk({tag, ".data"},  bus.oData, w.data);
            chk({tag, ".dst"},   {27'd0, bus.oDstReg}, {27'd0, w.dst});
            chk({tag, ".beat"},  {31'd0, bus.oBeat},   {31'd0, w.beat});
            chk({tag, ".stall"}, {31'd0, bus.oStallUp}, {31'd0, w.stall});
        end
    endtask

    task automatic dw_store(logic [31:0] a, logic [31:0] lo,
                            logic [31:0] hi, logic [4:0] r);
        clr();
        bus.iValid   = 1'b1;
        bus.iMWrite  = 1'b1;
        bus.iDW      = 1'b1;
        bus.iALURes  = a;
        bus.iStoreLo = lo;
        bus.iStoreHi = hi;
        bus.iDstReg  = r;
    endtask

    // reference model state for the random phase
    exp_t        m;
    logic        m_dw2;
    logic [31:0] m_hi;

    task automatic model_step();
        logic live;
        logic dbl;
        if (!bus.iMemWait) begin
            if (m_dw2) begin
                m.addr = m.addr + 32'd4;
                m.data = m_hi;
                m.dst  = {m.dst[4:1], 1'b1};
                m.beat = 1'b1;
                m_dw2  = 1'b0;
            end else begin
                live   = bus.iValid && !bus.iFlush;
                dbl    = live && bus.iDW &&
                         (bus.iMWrite || bus.iWBsrc == WB_MEM);
                m.rw   = live && bus.iRWrite;
                m.mw   = live && bus.iMWrite;
                m.fl   = bus.iFloat;
                m.wb   = bus.iWBsrc;
                m.addr = bus.iALURes;
                m.data = bus.iStoreLo;
                m.dst  = bus.iDstReg;
                m.beat = 1'b0;
                if (dbl) begin
                    m_hi  = bus.iStoreHi;
                    m_dw2 = 1'b1;
                end
            end
        end
        m.stall = m_dw2 || bus.iMemWait;
    endtask

    initial begin
        clr();
        #1;
        chk("rst.addr",  bus.oAddr, 32'd0);
        chk("rst.stall", {31'd0, bus.oStallUp}, 32'd0);
        bus.iMemWait = 1'b1;
        #1;
        chk("rst.stall_mw", {31'd0, bus.oStallUp}, 32'd1);
        bus.iMemWait = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single ALU op
        clr();
        bus.iValid  = 1'b1;
        bus.iRWrite = 1'b1;
        bus.iALURes = 32'h0000_1234;
        bus.iDstReg = 5'd7;
        cyc(mk(1, 0, WB_ALU, 32'h1234, 32'h0, 5'd7, 0, 0), "alu");

        // DW store
        dw_store(32'h100, 32'hAAAA_AAAA, 32'h5555_5555, 5'd0);
        cyc(mk(0, 1, WB_ALU, 32'h100, 32'hAAAA_AAAA, 5'd0, 0, 1), "dws1");
        clr();
        cyc(mk(0, 1, WB_ALU, 32'h104, 32'h5555_5555, 5'd1, 1, 0), "dws2");

        // DW load across the address wrap
        clr();
        bus.iValid  = 1'b1;
        bus.iRWrite = 1'b1;
        bus.iDW     = 1'b1;
        bus.iWBsrc  = WB_MEM;
        bus.iALURes = 32'hFFFF_FFFC;
        bus.iDstReg = 5'd4;
        cyc(mk(1, 0, WB_MEM, 32'hFFFF_FFFC, 32'h0, 5'd4, 0, 1), "dwl1");
        clr();
        cyc(mk(1, 0, WB_MEM, 32'h0, 32'h0, 5'd5, 1, 0), "dwl2");

        // DW with no memory access stays single-beat
        clr();
        bus.iValid  = 1'b1;
        bus.iRWrite = 1'b1;
        bus.iDW     = 1'b1;
        bus.iALURes = 32'h40;
        cyc(mk(1, 0, WB_ALU, 32'h40, 32'h0, 5'd0, 0, 0), "dwalu");

        // flush in IDLE
        clr();
        bus.iValid   = 1'b1;
        bus.iFlush   = 1'b1;
        bus.iRWrite  = 1'b1;
        bus.iMWrite  = 1'b1;
        bus.iALURes  = 32'h55;
        bus.iStoreLo = 32'h11;
        bus.iDstReg  = 5'd3;
        cyc(mk(0, 0, WB_ALU, 32'h55, 32'h11, 5'd3, 0, 0), "flush");

        // flush during DW2 is ignored
        dw_store(32'h200, 32'h1, 32'h2, 5'd0);
        cyc(mk(0, 1, WB_ALU, 32'h200, 32'h1, 5'd0, 0, 1), "fdw1");
        clr();
        bus.iValid  = 1'b1;
        bus.iFlush  = 1'b1;
        bus.iRWrite = 1'b1;
        bus.iALURes = 32'h999;
        cyc(mk(0, 1, WB_ALU, 32'h204, 32'h2, 5'd1, 1, 0), "fdw2");

        // memory wait in DW2
        dw_store(32'h300, 32'hA, 32'hB, 5'd8);
        cyc(mk(0, 1, WB_ALU, 32'h300, 32'hA, 5'd8, 0, 1), "mw1");
        clr();
        bus.iMemWait = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc(mk(0, 1, WB_ALU, 32'h300, 32'hA, 5'd8, 0, 1), "mwhold");
        bus.iMemWait = 1'b0;
        cyc(mk(0, 1, WB_ALU, 32'h304, 32'hB, 5'd9, 1, 0), "mw2");

        // reset mid-DW2
        dw_store(32'h400, 32'hC, 32'hD, 5'd2);
        cyc(mk(0, 1, WB_ALU, 32'h400, 32'hC, 5'd2, 0, 1), "rdw1");
        clr();
        rst = 1'b1;
        #1;
        chk("rdw.mw",    {31'd0, bus.oMWrite}, 32'd0);
        chk("rdw.addr",  bus.oAddr, 32'd0);
        chk("rdw.data",  bus.oData, 32'd0);
        chk("rdw.dst",   {27'd0, bus.oDstReg}, 32'd0);
        chk("rdw.stall", {31'd0, bus.oStallUp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.iValid  = 1'b1;
        bus.iRWrite = 1'b1;
        bus.iALURes = 32'h77;
        bus.iDstReg = 5'd6;
        cyc(mk(1, 0, WB_ALU, 32'h77, 32'h0, 5'd6, 0, 0), "rdwpost");

        // random traffic against the model
        clr();
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m     = '0;
        m_dw2 = 1'b0;
        m_hi  = '0;
        for (int i = 0; i < 300; i++) begin
            bus.iValid   = ($urandom_range(0, 3) != 0);
            bus.iFlush   = ($urandom_range(0, 4) == 0);
            bus.iMemWait = ($urandom_range(0, 3) == 0);
            bus.iRWrite  = 1'($urandom);
            bus.iDW      = 1'($urandom);
            bus.iFloat   = 1'($urandom);
            bus.iMWrite  = 1'($urandom);
            bus.iWBsrc   = 2'($urandom_range(0, 2));
            bus.iALURes  = $urandom;
            bus.iStoreLo = $urandom;
            bus.iStoreHi = $urandom;
            bus.iDstReg  = 5'($urandom);
            model_step();
            cyc(m, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exmem.md
EXMEM -- requirements
Module: EXMEM

Interface
REQ-001 SHALL expose: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL expose: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: iValid  in  1  EX stage presents a real instruction (0 = bubble).
REQ-004 SHALL expose: iFlush  in  1  squash the instruction presented this cycle.
REQ-005 SHALL expose: iMemWait  in  1  data memory busy; hold all state and outputs.
REQ-006 SHALL expose: iRWrite, iDW, iFloat, iMWrite  in  1 each  control bits from EX.
REQ-007 SHALL expose: iWBsrc  in  2  write-back source code (package constants).
REQ-008 SHALL expose: iALURes  in  32  ALU result / effective address.
REQ-009 SHALL expose: iStoreLo, iStoreHi  in  32 each  store data, low and high words.
REQ-010 SHALL expose: iDstReg  in  5  destination register.
REQ-011 SHALL expose: oRWrite, oFloat, oMWrite  out  1 each  registered controls to MEM/WB.
REQ-012 SHALL expose: oWBsrc  out  2  registered write-back source.
REQ-013 SHALL expose: oAddr  out  32  memory address / ALU result for this beat.
REQ-014 SHALL expose: oData  out  32  store data for this beat.
REQ-015 SHALL expose: oDstReg  out  5  destination register for this beat.
REQ-016 SHALL expose: oBeat  out  1  0 = single or first DW beat, 1 = second DW beat.
REQ-017 SHALL expose: oStallUp  out  1  combinational; 1 = EX must hold its inputs this cycle.

Function
REQ-018 SHALL be a two-state FSM: IDLE, DW2.
REQ-019 In IDLE with iMemWait=0, SHALL capture inputs on the rising edge; latency one cycle.
REQ-020 Captured controls (oRWrite, oMWrite) SHALL be forced to 0 when iValid=0 or iFlush=1; datapath fields still load.
REQ-021 A captured op is "memory double" when iValid=1, iFlush=0, iDW=1, and (iMWrite=1 or iWBsrc=WB_MEM).
REQ-022 On capture of a memory-double op: oAddr=iALURes, oData=iStoreLo, oDstReg=iDstReg, oBeat=0; next state DW2.
REQ-023 Non-double capture SHALL set oData=iStoreLo, oBeat=0, and remain in IDLE.
REQ-024 In DW2 with iMemWait=0, next edge: oAddr=previous oAddr+4 (mod 2^32, wraps), oData=latched high word, oDstReg=previous oDstReg|5'b00001, oBeat=1, other controls unchanged; next state IDLE.
REQ-025 High store word SHALL be latched internally at first-beat capture.
REQ-026 oStallUp SHALL equal (state==DW2) OR iMemWait.
REQ-027 iMemWait=1 SHALL hold state, all outputs and internal latches unchanged (no capture, no beat advance).
REQ-028 iFlush in DW2 SHALL be ignored (in-flight op is older than the flushing branch); input is not captured in DW2.
REQ-029 Priority per edge: rst > iMemWait > DW2 advance > flush/bubble > capture.
REQ-030 iDW=1 with neither memory write nor WB_MEM SHALL be a single-beat op (no DW2 entry).

Reset
REQ-031 rst=1 SHALL asynchronously set state=IDLE and every output register to 0 (oRWrite, oFloat, oMWrite, oWBsrc, oAddr, oData, oDstReg, oBeat, high-word latch).
REQ-032 Reset during DW2 SHALL abandon the second beat; first edge after release behaves as IDLE capture.
REQ-033 oStallUp SHALL be 0 while rst=1 unless iMemWait=1.

Structure
REQ-034 WB_ALU=2'b00, WB_MEM=2'b01, WB_PC=2'b10 and state encodings IDLE/DW2 SHALL live in the shared pipeline package.
REQ-035 Single module; no sub-module; DW sequencing is inline FSM.

Verification
REQ-036 Single ALU op: iValid=1, iRWrite=1, iALURes=0x0000_1234, iDstReg=7 -> next cycle oRWrite=1, oAddr=0x1234, oDstReg=7, oBeat=0, oStallUp=0.
REQ-037 DW store: iMWrite=1, iDW=1, iALURes=0x100, iStoreLo=0xAAAA_AAAA, iStoreHi=0x5555_5555 -> cycle1 oAddr=0x100/oData=0xAAAAAAAA/oBeat=0, oStallUp=1; cycle2 oAddr=0x104/oData=0x55555555/oBeat=1.
REQ-038 DW load wrap: iWBsrc=WB_MEM, iDW=1, iALURes=0xFFFF_FFFC, iDstReg=4 -> beat1 oAddr=0xFFFFFFFC, oDstReg=4; beat2 oAddr=0x0000_0000, oDstReg=5.
REQ-039 Flush/bubble: iFlush=1 with iRWrite=1, iMWrite=1 in IDLE -> next cycle oRWrite=0, oMWrite=0; iFlush=1 during DW2 -> second beat still issues with oMWrite=1.
REQ-040 iMemWait=1 for 3 cycles in DW2 -> outputs frozen at beat 1, oStallUp=1 throughout; beat 2 issues the edge after iMemWait falls.
REQ-041 rst asserted mid-DW2 -> all outputs 0 immediately (no clock), state IDLE after release.
